// File: rtl/uart_rx_frame_check_if.sv
// RX sampler <-> frame checker bundle: bit strobes in, completed frame and error flags out.
`timescale 1ns/1ps
interface uart_rx_frame_check_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  frame_start;
  logic                  valid;
  logic                  sampled_bit;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;
  logic                  busy;

  modport master (
    output frame_start, valid, sampled_bit,
    input  data_out, data_valid, par_err, stp_err, busy
  );

  modport slave (
    input  frame_start, valid, sampled_bit,
    output data_out, data_valid, par_err, stp_err, busy
  );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: LSB-first deserialiser with serial parity (even/odd/mark/space) and 1/2 stop checks.
// Optional saturating error counters are built when UART_RX_ERR_CNT_EN is defined.
`timescale 1ns/1ps
module uart_rx_frame_check #(
  parameter int DATA_WIDTH = 8
`ifdef UART_RX_ERR_CNT_EN
  , parameter int CNT_WIDTH = 8
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_TYP,
  input  logic                 STP2,
`ifdef UART_RX_ERR_CNT_EN
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stp_err_cnt,
`endif
  uart_rx_frame_check_if.slave rx
);

  localparam int BCW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP1, STOP2} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [BCW-1:0]        bitcnt_q, bitcnt_d;
  logic                  par_acc_q, par_acc_d;
  logic                  par_en_q, par_en_d;
  logic [1:0]            par_typ_q, par_typ_d;
  logic                  stp2_q, stp2_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;
  logic                  busy_q, busy_d;
  logic                  done;
  logic                  exp_par;

  always_comb begin
    exp_par = par_acc_q;
    case (par_typ_q)
      2'b00:   exp_par = par_acc_q;
      2'b01:   exp_par = ~par_acc_q;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bitcnt_d     = bitcnt_q;
    par_acc_d    = par_acc_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    stp2_d       = stp2_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    par_err_d    = par_err_q;
    stp_err_d    = stp_err_q;
    done         = 1'b0;
    // frame_start aborts anything in flight and swallows a coincident strobe
    if (rx.frame_start) begin
      par_en_d  = PAR_EN;
      par_typ_d = PAR_TYP;
      stp2_d    = STP2;
      bitcnt_d  = '0;
      par_acc_d = 1'b0;
      par_err_d = 1'b0;
      stp_err_d = 1'b0;
      state_d   = DATA;
    end else if (rx.valid) begin
      case (state_q)
        DATA: begin
          shreg_d   = {rx.sampled_bit, shreg_q[DATA_WIDTH-1:1]};
          par_acc_d = par_acc_q ^ rx.sampled_bit;
          bitcnt_d  = bitcnt_q + 1'b1;
          if (bitcnt_q == BCW'(DATA_WIDTH-1)) state_d = par_en_q ? PARITY : STOP1;
        end
        PARITY: begin
          par_err_d = (rx.sampled_bit != exp_par);
          state_d   = STOP1;
        end
        STOP1: begin
          stp_err_d = ~rx.sampled_bit;
          if (stp2_q) state_d = STOP2;
          else        done    = 1'b1;
        end
        STOP2: begin
          stp_err_d = stp_err_q | ~rx.sampled_bit;
          done      = 1'b1;
        end
        default: ;
      endcase
    end
    if (done) begin
      data_out_d   = shreg_q;
      data_valid_d = 1'b1;
      state_d      = IDLE;
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      par_acc_q    <= 1'b0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 2'b00;
      stp2_q       <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      par_acc_q    <= par_acc_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      stp2_q       <= stp2_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = data_valid_q;
  assign rx.par_err    = par_err_q;
  assign rx.stp_err    = stp_err_q;
  assign rx.busy       = busy_q;

`ifdef UART_RX_ERR_CNT_EN
  logic [CNT_WIDTH-1:0] par_cnt_q, par_cnt_d;
  logic [CNT_WIDTH-1:0] stp_cnt_q, stp_cnt_d;

  // counters move on the same edge that raises data_valid, so they are current during the pulse
  always_comb begin
    par_cnt_d = par_cnt_q;
    stp_cnt_d = stp_cnt_q;
    if (cnt_clr) begin
      par_cnt_d = '0;
      stp_cnt_d = '0;
    end else if (done) begin
      if (par_err_d && (par_cnt_q != '1)) par_cnt_d = par_cnt_q + 1'b1;
      if (stp_err_d && (stp_cnt_q != '1)) stp_cnt_d = stp_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_cnt_q <= '0;
      stp_cnt_q <= '0;
    end else begin
      par_cnt_q <= par_cnt_d;
      stp_cnt_q <= stp_cnt_d;
    end
  end

  assign par_err_cnt = par_cnt_q;
  assign stp_err_cnt = stp_cnt_q;
`endif

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Bench for uart_rx_frame_check: table of frames plus hand sequences, scoreboard queue per DUT.
`timescale 1ns/1ps
module tb_uart_rx_frame_check;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic       PAR_EN, STP2, sel7;
  logic [1:0] PAR_TYP;
  logic       frame_start, valid, sampled_bit;

  uart_rx_frame_check_if #(.DATA_WIDTH(8)) rx8 ();
  uart_rx_frame_check_if #(.DATA_WIDTH(7)) rx7 ();

  assign rx8.frame_start = frame_start & ~sel7;
  assign rx7.frame_start = frame_start & sel7;
  assign rx8.valid       = valid;
  assign rx7.valid       = valid;
  assign rx8.sampled_bit = sampled_bit;
  assign rx7.sampled_bit = sampled_bit;

`ifdef UART_RX_ERR_CNT_EN
  logic       cnt_clr;
  logic [1:0] pcnt8, scnt8;
  logic [7:0] pcnt7, scnt7;
  uart_rx_frame_check #(.DATA_WIDTH(8), .CNT_WIDTH(2)) dut8 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP2(STP2),
    .cnt_clr(cnt_clr), .par_err_cnt(pcnt8), .stp_err_cnt(scnt8), .rx(rx8));
  uart_rx_frame_check #(.DATA_WIDTH(7), .CNT_WIDTH(8)) dut7 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP2(STP2),
    .cnt_clr(cnt_clr), .par_err_cnt(pcnt7), .stp_err_cnt(scnt7), .rx(rx7));
`else
  uart_rx_frame_check #(.DATA_WIDTH(8)) dut8 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP2(STP2), .rx(rx8));
  uart_rx_frame_check #(.DATA_WIDTH(7)) dut7 (
    .CLK(CLK), .RST(RST), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STP2(STP2), .rx(rx7));
`endif

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       serr;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic [1:0] typ;
    logic       stp2;
    logic       pbit;
    logic       s1;
    logic       s2;
    int         gap;
    logic       perr;
    logic       serr;
  } vec_t;

  exp_t q8[$];
  exp_t q7[$];
  exp_t e8, e7;
  vec_t tbl[8];
  int   checks = 0;
  int   errors = 0;
  int   pm = 0, sm = 0;
  bit   cnt_track = 1'b1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // scoreboard: every data_valid must match the oldest pending expectation
  always @(negedge CLK) begin
    if (rx8.data_valid) begin
      if (q8.size() == 0) chk("dv8_unexpected", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk("data8", 32'(rx8.data_out), 32'(e8.data));
        chk("perr8", 32'(rx8.par_err), 32'(e8.perr));
        chk("serr8", 32'(rx8.stp_err), 32'(e8.serr));
        chk("busy8_at_dv", 32'(rx8.busy), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
        if (cnt_track) begin
          if (e8.perr && pm < 3) pm++;
          if (e8.serr && sm < 3) sm++;
          chk("pcnt8", 32'(pcnt8), 32'(pm));
          chk("scnt8", 32'(scnt8), 32'(sm));
        end
`endif
      end
    end
    if (rx7.data_valid) begin
      if (q7.size() == 0) chk("dv7_unexpected", 32'd1, 32'd0);
      else begin
        e7 = q7.pop_front();
        chk("data7", 32'(rx7.data_out), 32'(e7.data));
        chk("perr7", 32'(rx7.par_err), 32'(e7.perr));
        chk("serr7", 32'(rx7.stp_err), 32'(e7.serr));
      end
    end
  end

  task automatic pulse_start(input logic pen, input logic [1:0] typ, input logic stp2);
    PAR_EN = pen; PAR_TYP = typ; STP2 = stp2;
    frame_start = 1'b1;
    @(posedge CLK); #1;
    frame_start = 1'b0;
    // mid-frame changes must be ignored by the shadow registers
    PAR_EN = ~pen; PAR_TYP = ~typ; STP2 = ~stp2;
  endtask

  task automatic send_bit(input logic b, input int gap);
    valid = 1'b1; sampled_bit = b;
    @(posedge CLK); #1;
    valid = 1'b0; sampled_bit = ~b;
    repeat (gap) begin @(posedge CLK); #1; end
  endtask

  task automatic send_frame(input vec_t v, input int nbits);
    pulse_start(v.pen, v.typ, v.stp2);
    for (int i = 0; i < nbits; i++) send_bit(v.data[i], v.gap);
    if (v.pen) send_bit(v.pbit, v.gap);
    send_bit(v.s1, v.gap);
    if (v.stp2) send_bit(v.s2, v.gap);
  endtask

  task automatic push8(input logic [7:0] d, input logic pe, input logic se);
    exp_t e;
    e.data = d; e.perr = pe; e.serr = se;
    q8.push_back(e);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 30 && (q8.size() + q7.size()) != 0; i++) @(posedge CLK);
    #1;
    chk(name, 32'(q8.size() + q7.size()), 32'd0);
  endtask

  initial begin
    exp_t e;
    vec_t v;
    //             data   pen typ   stp2 pbit s1 s2 gap perr serr
    tbl[0] = '{8'hA5, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0};
    tbl[1] = '{8'h07, 1, 2'b00, 0, 0, 1, 1, 2, 1, 0};
    tbl[2] = '{8'h00, 1, 2'b10, 0, 0, 1, 1, 0, 1, 0};
    tbl[3] = '{8'hF0, 1, 2'b11, 0, 0, 1, 1, 1, 0, 0};
    tbl[4] = '{8'h3C, 1, 2'b01, 1, 1, 1, 0, 0, 0, 1};
    tbl[5] = '{8'hFF, 1, 2'b00, 0, 0, 0, 1, 0, 0, 1};
    tbl[6] = '{8'h81, 1, 2'b10, 1, 1, 0, 1, 2, 0, 1};
    tbl[7] = '{8'h5A, 1, 2'b11, 0, 1, 1, 1, 0, 1, 0};

    frame_start = 0; valid = 0; sampled_bit = 1;
    PAR_EN = 0; PAR_TYP = 2'b00; STP2 = 0; sel7 = 0;
`ifdef UART_RX_ERR_CNT_EN
    cnt_clr = 0;
`endif
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_data", 32'(rx8.data_out), 32'd0);
    chk("rst_dv", 32'(rx8.data_valid), 32'd0);
    chk("rst_perr", 32'(rx8.par_err), 32'd0);
    chk("rst_serr", 32'(rx8.stp_err), 32'd0);
    chk("rst_busy", 32'(rx8.busy), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    chk("rst_pcnt", 32'(pcnt8), 32'd0);
    chk("rst_scnt", 32'(scnt8), 32'd0);
`endif
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // strobes while idle are ignored
    for (int i = 0; i < 3; i++) send_bit(1'b0, 0);
    @(negedge CLK);
    chk("idle_valid_busy", 32'(rx8.busy), 32'd0);
    @(posedge CLK); #1;

    // 8E1 with bad parity: flag one cycle after the parity strobe, busy during frame
    push8(8'h07, 1, 0);
    pulse_start(1'b1, 2'b00, 1'b0);
    @(negedge CLK);
    chk("busy_after_start", 32'(rx8.busy), 32'd1);
    #4;
    for (int i = 0; i < 8; i++) send_bit(i < 3, 0);
    send_bit(1'b0, 0);
    @(negedge CLK);
    chk("perr_timing", 32'(rx8.par_err), 32'd1);
    chk("dv_before_stop", 32'(rx8.data_valid), 32'd0);
    #4;
    send_bit(1'b1, 0);
    @(posedge CLK); #1;

    foreach (tbl[i]) begin
      push8(tbl[i].data, tbl[i].perr, tbl[i].serr);
      send_frame(tbl[i], 8);
    end
    drain("drain_table");

    // 7-bit, odd parity, two stops with the second one low
    sel7 = 1'b1;
    e.data = 8'h55; e.perr = 1'b0; e.serr = 1'b1;
    q7.push_back(e);
    v = '{8'h55, 1, 2'b01, 1, 1, 1, 0, 0, 0, 1};
    send_frame(v, 7);
    sel7 = 1'b0;
    drain("drain_dw7");

    // abort after 4 data bits, then a clean 0x3C frame
    pulse_start(1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
    push8(8'h3C, 0, 0);
    v = '{8'h3C, 0, 2'b00, 0, 0, 1, 1, 0, 0, 0};
    send_frame(v, 8);
    drain("drain_abort");
`ifdef UART_RX_ERR_CNT_EN
    chk("abort_pcnt", 32'(pcnt8), 32'(pm));
    chk("abort_scnt", 32'(scnt8), 32'(sm));
`endif

    // frame_start coincides with the last stop strobe: old frame lost, new one proceeds
    pulse_start(1'b0, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1, 0);
    PAR_EN = 0; PAR_TYP = 2'b00; STP2 = 0;
    frame_start = 1'b1; valid = 1'b1; sampled_bit = 1'b1;
    @(posedge CLK); #1;
    frame_start = 1'b0; valid = 1'b0;
    push8(8'h22, 0, 0);
    for (int i = 0; i < 8; i++) send_bit(i == 1 || i == 5, 0);
    send_bit(1'b1, 0);
    drain("drain_same_cycle");

`ifdef UART_RX_ERR_CNT_EN
    cnt_clr = 1'b1;
    @(posedge CLK); #1;
    cnt_clr = 1'b0;
    pm = 0; sm = 0;
    v = '{8'h07, 1, 2'b00, 0, 0, 1, 1, 0, 1, 0};
    for (int k = 0; k < 5; k++) begin
      push8(8'h07, 1, 0);
      send_frame(v, 8);
    end
    drain("drain_sat");
    chk("sat_pcnt", 32'(pcnt8), 32'd3);
    // clear wins over a coincident increment
    cnt_track = 1'b0;
    push8(8'h07, 1, 0);
    pulse_start(1'b1, 2'b00, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(i < 3, 0);
    send_bit(1'b0, 0);
    cnt_clr = 1'b1;
    send_bit(1'b1, 0);
    @(posedge CLK); #1;
    cnt_clr = 1'b0;
    @(negedge CLK);
    chk("clr_pcnt", 32'(pcnt8), 32'd0);
    pm = 0; sm = 0;
    cnt_track = 1'b1;
    drain("drain_clr");
`endif

    // asynchronous reset mid-frame
    pulse_start(1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    #2 RST = 1'b0;
    #1;
    chk("arst_data", 32'(rx8.data_out), 32'd0);
    chk("arst_dv", 32'(rx8.data_valid), 32'd0);
    chk("arst_perr", 32'(rx8.par_err), 32'd0);
    chk("arst_serr", 32'(rx8.stp_err), 32'd0);
    chk("arst_busy", 32'(rx8.busy), 32'd0);
    chk("arst_data7", 32'(rx7.data_out), 32'd0);
`ifdef UART_RX_ERR_CNT_EN
    chk("arst_pcnt", 32'(pcnt8), 32'd0);
    chk("arst_scnt", 32'(scnt8), 32'd0);
    pm = 0; sm = 0;
`endif
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    push8(8'hC3, 0, 0);
    v = '{8'hC3, 0, 2'b00, 0, 0, 1, 1, 1, 0, 0};
    send_frame(v, 8);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
